slave_fifo_node: RTL and testbench
==================================

Name: slave_fifo_node

Overview:
- Per-channel slave stage of the MCDF datapath. It sits between an upstream data channel and the arbiter/formatter, and is instantiated three times (slv0..slv2).
- It buffers incoming words in a FIFO and reports free space (margin) to the control register block. It takes its enable and packet-length settings from that block.
- It raises a packet request to the arbiter once a full packet is buffered, then streams that packet out on grant.

Parameters:
DW, 32, data word width
DEPTH, 64, FIFO depth in words (power of two)
AW, 6, FIFO pointer width, log2(DEPTH)

Ports:
clk_i  in  1  system clock
rstn_i  in  1  asynchronous active-low reset
ch_valid_i  in  1  upstream word valid
ch_data_i  in  DW  upstream word
ch_ready_o  out  1  upstream ready; a transfer occurs when valid and ready are both high in the same cycle
slv_en_i  in  1  channel enable, from control register bit 0
pkglen_i  in  3  packet length code, from control register bits 5:3
margin_o  out  8  free FIFO entries, to control register status
req_o  out  1  packet request to arbiter
ack_i  in  1  arbiter grant for the pending request
rd_i  in  1  downstream pop strobe
data_o  out  DW  popped word (registered)
val_o  out  1  data_o valid

Behaviour:
- Reset (rstn_i low, asynchronous, active-low): pointers=0, count=0, FSM=IDLE.
  - Output reset values: ch_ready_o=0, margin_o=64, req_o=0, data_o=0, val_o=0.
- Storage and count:
  - count is a 7-bit occupancy register, 0..DEPTH.
  - full = (count==DEPTH); empty = (count==0).
  - Pointers wrap modulo DEPTH.
- Upstream handshake:
  - ch_ready_o = slv_en_i & ~full, combinational from registered state.
  - A write stores ch_data_i at wptr and increments wptr.
- margin_o = DEPTH - count, zero-extended to 8 bits.
  - It updates in the cycle after a write or pop.
  - A simultaneous write and pop leaves count and margin unchanged.
- Packet length decode: pkglen 0→4 words, 1→8, 2→16, 3→32; codes 4..7 → 32.
- FSM states: IDLE, REQ, XFER.
  - IDLE→REQ when slv_en_i=1 and count >= decoded length. On that transition the length is latched into rem (6 bits).
  - REQ: req_o=1. REQ→XFER on ack_i=1.
  - XFER: req_o=0. Each pop decrements rem. XFER→IDLE in the cycle after the pop with rem==1.
- Pop rules:
  - A pop occurs only when rd_i=1, FSM=XFER and not empty; rd_i in any other state is ignored.
  - Pop latency is one cycle: data_o takes mem[rptr] and val_o=1 in the cycle after the pop.
  - val_o=0 in any cycle not following a pop; data_o holds its last value.
- Simultaneous events:
  - Write and pop in the same cycle: both occur.
  - Write into an empty FIFO with rd_i high: only the write occurs (no bypass).
  - When full, ch_ready_o=0, so only a pop can occur.
- pkglen_i changes while in REQ/XFER do not affect the in-flight packet (the latched rem is used).
- slv_en_i deasserted:
  - Blocks writes immediately and blocks new IDLE→REQ transitions.
  - An in-flight REQ/XFER packet completes normally; buffered data is retained.
- ack_i while in IDLE or XFER is ignored.
- Reset asserted mid-packet: all state is cleared immediately, and the FIFO contents are discarded.

Optional Feature:
- Macro: SLV_FIFO_EOP_EN.
- With the macro defined:
  - Extra output port eop_o (1 bit), registered, reset 0.
  - eop_o=1 together with val_o for the word popped when rem==1, i.e. the last word of the packet; 0 otherwise.
- Without the macro: port eop_o is absent and the rest of the behaviour is identical.

Test Plan:
- Reset value check: assert reset, release, no traffic → margin_o=64, ch_ready_o=0 while slv_en_i=0, req_o=0, val_o=0.
- Packet threshold: slv_en_i=1, pkglen_i=0, write 3 words → req_o stays 0, margin_o=61. Write 4th word → req_o=1 next cycle, margin_o=60.
- Full transfer: pkglen_i=1, write 8 words 0x100..0x107, ack_i pulse, rd_i held 8 cycles → data_o 0x100..0x107 each with val_o=1 one cycle after each pop. FSM returns to IDLE, margin_o=64. With SLV_FIFO_EOP_EN, eop_o=1 only on 0x107.
- Full boundary: write 64 words → ch_ready_o=0, margin_o=0, and a 65th valid is not accepted. One pop in XFER with a concurrent valid → no write that cycle; next cycle ch_ready_o=1.
- Simultaneous write/pop: count=10 in XFER, valid and rd_i together → margin_o stays 54. Wrap-around: push/pop 130 words total → data order preserved across the pointer wrap.
- Disable mid-packet and reset: drop slv_en_i during XFER → ch_ready_o=0 immediately and the packet completes. Assert rstn_i mid-XFER → req_o=0, val_o=0, margin_o=64 asynchronously.

Source files
------------

// File: rtl/slave_fifo_node_if.sv
// Handshake and configuration bundle for one MCDF slave channel.
// The eop_o member exists only when SLV_FIFO_EOP_EN is defined.
interface slave_fifo_node_if #(
  parameter int DW = 32
);
  logic          ch_valid_i;
  logic [DW-1:0] ch_data_i;
  logic          ch_ready_o;
  logic          slv_en_i;
  logic [2:0]    pkglen_i;
  logic [7:0]    margin_o;
  logic          req_o;
  logic          ack_i;
  logic          rd_i;
  logic [DW-1:0] data_o;
  logic          val_o;
`ifdef SLV_FIFO_EOP_EN
  logic          eop_o;

  modport slave (
    input  ch_valid_i, ch_data_i, slv_en_i, pkglen_i, ack_i, rd_i,
    output ch_ready_o, margin_o, req_o, data_o, val_o, eop_o
  );

  modport master (
    output ch_valid_i, ch_data_i, slv_en_i, pkglen_i, ack_i, rd_i,
    input  ch_ready_o, margin_o, req_o, data_o, val_o, eop_o
  );
`else
  modport slave (
    input  ch_valid_i, ch_data_i, slv_en_i, pkglen_i, ack_i, rd_i,
    output ch_ready_o, margin_o, req_o, data_o, val_o
  );

  modport master (
    output ch_valid_i, ch_data_i, slv_en_i, pkglen_i, ack_i, rd_i,
    input  ch_ready_o, margin_o, req_o, data_o, val_o
  );
`endif
endinterface

// File: rtl/slave_fifo_node.sv
// MCDF per-channel slave stage: buffers upstream words, requests the arbiter once a
// packet is buffered, streams it out on grant. Define SLV_FIFO_EOP_EN to add eop_o.
module slave_fifo_node #(
  parameter int DW    = 32,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  slave_fifo_node_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  localparam logic [AW:0] C_DEPTH  = (AW+1)'(DEPTH);
  localparam logic [7:0]  C_DEPTH8 = 8'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_margin;
  state_t        r_state;
  logic [5:0]    r_rem;
  logic          r_req;
  logic [DW-1:0] r_data;
  logic          r_val;
`ifdef SLV_FIFO_EOP_EN
  logic          r_eop;
`endif

  logic          w_full;
  logic          w_empty;
  logic          w_ready;
  logic          w_wr;
  logic          w_rd;
  logic [5:0]    w_len;
  logic [AW:0]   w_count_nxt;

  function automatic logic [5:0] decode_len(input logic [2:0] code);
    logic [5:0] len;
    case (code)
      3'd0:    len = 6'd4;
      3'd1:    len = 6'd8;
      3'd2:    len = 6'd16;
      3'd3:    len = 6'd32;
      default: len = 6'd32;
    endcase
    return len;
  endfunction

  // Status decode and transfer qualification; a pop never bypasses an empty FIFO
  always_comb begin
    w_full  = (r_count == C_DEPTH);
    w_empty = (r_count == {(AW+1){1'b0}});
    w_ready = bus.slv_en_i & ~w_full;
    w_wr    = bus.ch_valid_i & w_ready;
    w_rd    = bus.rd_i & (r_state == ST_XFER) & ~w_empty;
    w_len   = decode_len(bus.pkglen_i);
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + {{AW{1'b0}}, 1'b1};
      2'b01:   w_count_nxt = r_count - {{AW{1'b0}}, 1'b1};
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array; contents are not reset, only the pointers are
  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_mem[r_wptr] <= bus.ch_data_i;
    end
  end

  // Pointers, occupancy and free-space status
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr   <= {AW{1'b0}};
      r_rptr   <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
      r_margin <= C_DEPTH8;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_rd) begin
        r_rptr <= r_rptr + {{(AW-1){1'b0}}, 1'b1};
      end
      r_count  <= w_count_nxt;
      r_margin <= C_DEPTH8 - {1'b0, w_count_nxt};
    end
  end

  // Packet FSM: rem is latched at request time so pkglen_i may change mid-packet
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
      r_rem   <= 6'd0;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.slv_en_i && (r_count >= {1'b0, w_len})) begin
            r_state <= ST_REQ;
            r_rem   <= w_len;
            r_req   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.ack_i) begin
            r_state <= ST_XFER;
            r_req   <= 1'b0;
          end
        end
        ST_XFER: begin
          if (w_rd) begin
            r_rem <= r_rem - 6'd1;
            if (r_rem == 6'd1) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_rem   <= 6'd0;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // Registered read port: data holds between pops, valid is a one-cycle pulse
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_data <= {DW{1'b0}};
      r_val  <= 1'b0;
`ifdef SLV_FIFO_EOP_EN
      r_eop  <= 1'b0;
`endif
    end else begin
      r_val <= w_rd;
      if (w_rd) begin
        r_data <= r_mem[r_rptr];
      end
`ifdef SLV_FIFO_EOP_EN
      r_eop <= w_rd & (r_rem == 6'd1);
`endif
    end
  end

  assign bus.ch_ready_o = w_ready;
  assign bus.margin_o   = r_margin;
  assign bus.req_o      = r_req;
  assign bus.data_o     = r_data;
  assign bus.val_o      = r_val;
`ifdef SLV_FIFO_EOP_EN
  assign bus.eop_o      = r_eop;
`endif

endmodule

// File: tb/tb_slave_fifo_node.sv
// Directed bench for slave_fifo_node: stimulus pushes expected pops into a queue,
// a negedge monitor pops and compares whenever val_o is high.
module tb_slave_fifo_node;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic clk;
  logic rstn;
  int   n_pass;
  int   n_total;
  exp_t sb[$];
  logic [31:0] model[$];
  exp_t m_e;

  slave_fifo_node_if #(.DW(32)) bus ();

  slave_fifo_node #(.DW(32), .DEPTH(64), .AW(6)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every val_o pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rstn && bus.val_o) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_val: data_o 0x%0h with no word expected at %0t", bus.data_o, $time);
      end else begin
        m_e = sb.pop_front();
        chk("data_o", bus.data_o, m_e.d);
`ifdef SLV_FIFO_EOP_EN
        chk("eop_o", {31'd0, bus.eop_o}, {31'd0, m_e.e});
`endif
      end
    end
  end

  task automatic write_word(input logic [31:0] d);
    bus.ch_valid_i = 1'b1;
    bus.ch_data_i  = d;
    @(posedge clk);
    #1;
    bus.ch_valid_i = 1'b0;
    model.push_back(d);
  endtask

  task automatic write_n(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) write_word(base + 32'(i));
  endtask

  task automatic wait_req_ack();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      if (bus.req_o) seen = 1'b1;
    end
    n_total++;
    if (seen) n_pass++;
    else $display("FAIL req_timeout: req_o stayed 0 expected 1 at %0t", $time);
    bus.ack_i = 1'b1;
    @(posedge clk);
    #1;
    bus.ack_i = 1'b0;
  endtask

  task automatic pop_k(input int n, input bit eop_last);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.d = model.pop_front();
      e.e = eop_last && (i == n - 1);
      sb.push_back(e);
      bus.rd_i = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.rd_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    exp_t e;
    n_pass = 0;
    n_total = 0;
    rstn = 1'b0;
    bus.ch_valid_i = 1'b0;
    bus.ch_data_i  = 32'd0;
    bus.slv_en_i   = 1'b0;
    bus.pkglen_i   = 3'd0;
    bus.ack_i      = 1'b0;
    bus.rd_i       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Reset values, channel disabled
    @(negedge clk);
    chk("rst_margin", {24'd0, bus.margin_o}, 32'd64);
    chk("rst_ready", {31'd0, bus.ch_ready_o}, 32'd0);
    chk("rst_req", {31'd0, bus.req_o}, 32'd0);
    chk("rst_val", {31'd0, bus.val_o}, 32'd0);
    chk("rst_data", bus.data_o, 32'd0);

    // Packet threshold with 4-word packets
    @(posedge clk);
    #1;
    bus.slv_en_i = 1'b1;
    bus.pkglen_i = 3'd0;
    write_n(32'h0A0, 3);
    @(negedge clk);
    chk("thr_req_3w", {31'd0, bus.req_o}, 32'd0);
    chk("thr_margin_3w", {24'd0, bus.margin_o}, 32'd61);
    chk("thr_ready", {31'd0, bus.ch_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    write_word(32'h0A3);
    @(negedge clk);
    chk("thr_margin_4w", {24'd0, bus.margin_o}, 32'd60);
    wait_req_ack();
    pop_k(4, 1'b1);
    @(negedge clk);
    chk("thr_margin_done", {24'd0, bus.margin_o}, 32'd64);

    // 8-word packet; pkglen changed mid-packet must not cut it short
    @(posedge clk);
    #1;
    bus.pkglen_i = 3'd1;
    write_n(32'h100, 8);
    wait_req_ack();
    bus.pkglen_i = 3'd0;
    pop_k(8, 1'b1);
    @(negedge clk);
    chk("xfer_margin_done", {24'd0, bus.margin_o}, 32'd64);
    chk("xfer_req_idle", {31'd0, bus.req_o}, 32'd0);

    // Full boundary with 32-word packets
    @(posedge clk);
    #1;
    bus.pkglen_i = 3'd3;
    write_n(32'h200, 64);
    @(negedge clk);
    chk("full_ready", {31'd0, bus.ch_ready_o}, 32'd0);
    chk("full_margin", {24'd0, bus.margin_o}, 32'd0);
    @(posedge clk);
    #1;
    bus.ch_valid_i = 1'b1;
    bus.ch_data_i  = 32'hDEAD;
    @(posedge clk);
    #1;
    bus.ch_valid_i = 1'b0;
    @(negedge clk);
    chk("full_65th_margin", {24'd0, bus.margin_o}, 32'd0);
    wait_req_ack();
    e.d = model.pop_front();
    e.e = 1'b0;
    sb.push_back(e);
    bus.ch_valid_i = 1'b1;
    bus.ch_data_i  = 32'hBEEF;
    bus.rd_i       = 1'b1;
    @(posedge clk);
    #1;
    bus.ch_valid_i = 1'b0;
    bus.rd_i       = 1'b0;
    @(negedge clk);
    chk("full_pop_ready", {31'd0, bus.ch_ready_o}, 32'd1);
    chk("full_pop_margin", {24'd0, bus.margin_o}, 32'd1);
    @(posedge clk);
    #1;
    pop_k(31, 1'b1);
    wait_req_ack();
    pop_k(32, 1'b1);
    @(negedge clk);
    chk("full_drain_margin", {24'd0, bus.margin_o}, 32'd64);

    // Simultaneous write and pop at count 10 in XFER
    @(posedge clk);
    #1;
    bus.pkglen_i = 3'd2;
    write_n(32'h300, 16);
    wait_req_ack();
    pop_k(6, 1'b0);
    @(negedge clk);
    chk("sim_margin_pre", {24'd0, bus.margin_o}, 32'd54);
    @(posedge clk);
    #1;
    e.d = model.pop_front();
    e.e = 1'b0;
    sb.push_back(e);
    model.push_back(32'h3FF);
    bus.ch_valid_i = 1'b1;
    bus.ch_data_i  = 32'h3FF;
    bus.rd_i       = 1'b1;
    @(posedge clk);
    #1;
    bus.ch_valid_i = 1'b0;
    bus.rd_i       = 1'b0;
    @(negedge clk);
    chk("sim_margin_post", {24'd0, bus.margin_o}, 32'd54);
    @(posedge clk);
    #1;
    pop_k(9, 1'b1);
    @(negedge clk);
    chk("sim_margin_left", {24'd0, bus.margin_o}, 32'd63);

    // Pointer wrap: 16 packets of 8 with one word carried over each time
    @(posedge clk);
    #1;
    bus.pkglen_i = 3'd1;
    for (int p = 0; p < 16; p++) begin
      write_n(32'h400 + 32'(p * 8), 8);
      wait_req_ack();
      pop_k(8, 1'b1);
    end
    @(negedge clk);
    chk("wrap_margin", {24'd0, bus.margin_o}, 32'd63);

    // Disable mid-packet: writes blocked at once, packet still completes
    @(posedge clk);
    #1;
    bus.pkglen_i = 3'd0;
    write_n(32'h4F0, 3);
    wait_req_ack();
    pop_k(2, 1'b0);
    bus.slv_en_i = 1'b0;
    @(negedge clk);
    chk("dis_ready", {31'd0, bus.ch_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    pop_k(2, 1'b1);
    bus.ch_valid_i = 1'b1;
    bus.ch_data_i  = 32'hBAD0;
    @(posedge clk);
    #1;
    bus.ch_valid_i = 1'b0;
    @(negedge clk);
    chk("dis_margin", {24'd0, bus.margin_o}, 32'd64);
    chk("dis_req", {31'd0, bus.req_o}, 32'd0);

    // Asynchronous reset in the middle of a packet
    @(posedge clk);
    #1;
    bus.slv_en_i = 1'b1;
    write_n(32'h500, 4);
    wait_req_ack();
    pop_k(1, 1'b0);
    bus.rd_i = 1'b1;
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_req", {31'd0, bus.req_o}, 32'd0);
    chk("arst_val", {31'd0, bus.val_o}, 32'd0);
    chk("arst_margin", {24'd0, bus.margin_o}, 32'd64);
    sb.delete();
    model.delete();
    bus.rd_i = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    write_n(32'h600, 4);
    wait_req_ack();
    pop_k(4, 1'b1);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("end_margin", {24'd0, bus.margin_o}, 32'd64);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
